// File: rtl/imm_encoder.sv
// Two-stage RISC-V immediate encoder: scatters an immediate into a base instruction
// word by format, flags unrepresentable immediates, and counts errored words delivered.
module imm_encoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_type,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  // Format codes mirror the decode side's param.v definitions.
  localparam logic [3:0] I_type_ext = 4'd1;
  localparam logic [3:0] S_type_ext = 4'd2;
  localparam logic [3:0] B_type_ext = 4'd3;
  localparam logic [3:0] U_type_ext = 4'd4;
  localparam logic [3:0] J_type_ext = 4'd5;

  logic        s1_valid;
  logic [3:0]  s1_type;
  logic [31:0] s1_imm;
  logic [31:0] s1_base;
  logic        s1_err;
  logic        s2_valid;
  logic        s1_adv;
  logic        in_err;
  logic [31:0] pack_word;

  assign s1_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s1_adv;
  assign out_valid = s2_valid;

  // A sign-extended field is representable only if every bit above it copies its top bit.
  always_comb begin
    in_err = 1'b0;
    case (in_type)
      I_type_ext,
      S_type_ext: in_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      B_type_ext: in_err = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      U_type_ext: in_err = |in_imm[11:0];
      J_type_ext: in_err = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      default:    in_err = 1'b1;
    endcase
  end

  always_comb begin
    pack_word = s1_base;
    case (s1_type)
      I_type_ext: pack_word[31:20] = s1_imm[11:0];
      S_type_ext: begin
        pack_word[31:25] = s1_imm[11:5];
        pack_word[11:7]  = s1_imm[4:0];
      end
      B_type_ext: begin
        pack_word[31]    = s1_imm[12];
        pack_word[7]     = s1_imm[11];
        pack_word[30:25] = s1_imm[10:5];
        pack_word[11:8]  = s1_imm[4:1];
      end
      U_type_ext: pack_word[31:12] = s1_imm[31:12];
      J_type_ext: begin
        pack_word[31]    = s1_imm[20];
        pack_word[19:12] = s1_imm[19:12];
        pack_word[20]    = s1_imm[11];
        pack_word[30:21] = s1_imm[10:1];
      end
      default: pack_word = s1_base;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_type  <= '0;
      s1_imm   <= '0;
      s1_base  <= '0;
      s1_err   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_type <= in_type;
        s1_imm  <= in_imm;
        s1_base <= in_base;
        s1_err  <= in_err;
      end
    end
  end

  // Stage 2 only reloads when its word is leaving, so the output holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= pack_word;
        out_err   <= s1_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (s2_valid && out_ready && out_err && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule
